// File: rtl/pram_sram_pkg.sv
// pram_sram_pkg: shared defaults, checker state encoding and error-counter limit
package pram_sram_pkg;
    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} chk_state_t;
endpackage

// File: rtl/pram_sram_log_fifo.sv
// pram_sram_log_fifo: first-word fall-through failure log; full pushes are dropped and flagged sticky
module pram_sram_log_fifo #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clr,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_syn,
    input  logic              pop,
    output logic              valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_syn,
    output logic              ovf
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_syn [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic empty, full, do_pop, do_push;
    assign empty   = count == '0;
    assign full    = count == (PW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // pointers, occupancy and sticky overflow; a pop frees the slot a same-cycle push needs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            ovf    <= ovf | (push && !do_push);
        end
    end
    // entry storage, no reset needed since reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_syn[wr_ptr]  <= push_syn;
        end
    end
    assign valid    = !empty;
    assign out_addr = empty ? '0 : mem_addr[rd_ptr];
    assign out_syn  = empty ? '0 : mem_syn[rd_ptr];
endmodule

// File: rtl/pram_sram_checker.sv
// pram_sram_checker: SRAM read-compare checker with verdict, first-failure capture and optional failure log (PRAM_SRAM_CHECKER_LOG_EN)
module pram_sram_checker
    import pram_sram_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LOG_DEPTH = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              valid,
    input  logic              pass_done,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] actual,
    output logic              good,
    output logic              bad,
    output logic              busy,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_addr,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_act,
    output logic              log_valid,
    input  logic              log_pop,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_syn,
    output logic              log_ovf
);
    chk_state_t state, state_nx;
    logic mismatch;
    assign mismatch = state == RUN && valid && !start && expected != actual;
    // state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else state <= state_nx;
    end
    // next state and verdict; start restarts from any state
    always_comb begin
        state_nx = start ? RUN : (state == RUN && pass_done) ? DONE : state;
        busy     = state == RUN;
        good     = state == DONE && err_count == '0;
        bad      = state == DONE && err_count != '0;
    end
    // error count and first-mismatch capture; a zero count marks the first failure of the pass
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_count  <= '0;
            first_addr <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (start) begin
            err_count  <= '0;
            first_addr <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (mismatch) begin
            err_count <= err_count == ERR_CNT_MAX ? err_count : err_count + 16'd1;
            if (err_count == '0) begin
                first_addr <= addr;
                first_exp  <= expected;
                first_act  <= actual;
            end
        end
    end
`ifdef PRAM_SRAM_CHECKER_LOG_EN
    pram_sram_log_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(LOG_DEPTH)) u_log (
        .clk       (clk),
        .clr_n     (clr_n),
        .clr       (start),
        .push      (mismatch),
        .push_addr (addr),
        .push_syn  (expected ^ actual),
        .pop       (log_pop),
        .valid     (log_valid),
        .out_addr  (log_addr),
        .out_syn   (log_syn),
        .ovf       (log_ovf)
    );
`else
    logic unused_log_pop;
    assign unused_log_pop = log_pop;
    assign log_valid = 1'b0;
    assign log_addr  = '0;
    assign log_syn   = '0;
    assign log_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_pram_sram_checker.sv
// tb_pram_sram_checker: table vectors, corner sequences and randomized passes against a queue-based model
module tb_pram_sram_checker;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int LD = 8;
`ifdef PRAM_SRAM_CHECKER_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif
    logic clk = 1'b0, clr_n = 1'b0, start = 1'b0, valid = 1'b0, pass_done = 1'b0, log_pop = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] expected = '0, actual = '0;
    logic good, bad, busy, log_valid, log_ovf;
    logic [15:0] err_count;
    logic [AW-1:0] first_addr, log_addr;
    logic [DW-1:0] first_exp, first_act, log_syn;

    always #5 clk = ~clk;

    pram_sram_checker #(.ADDR_W(AW), .DATA_W(DW), .LOG_DEPTH(LD)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .valid(valid), .pass_done(pass_done),
        .addr(addr), .expected(expected), .actual(actual),
        .good(good), .bad(bad), .busy(busy), .err_count(err_count),
        .first_addr(first_addr), .first_exp(first_exp), .first_act(first_act),
        .log_valid(log_valid), .log_pop(log_pop), .log_addr(log_addr), .log_syn(log_syn), .log_ovf(log_ovf)
    );

    int n_chk = 0, n_pass = 0;

    int m_state;
    int m_cnt;
    bit m_seen, m_ovf;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fexp, m_fact;
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_syn [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic void model_clear();
        m_cnt = 0; m_seen = 0; m_ovf = 0;
        m_faddr = '0; m_fexp = '0; m_fact = '0;
        q_addr.delete(); q_syn.delete();
    endfunction

    function automatic void model_clock();
        bit mm;
        if (start) begin
            model_clear();
            m_state = 1;
            return;
        end
        mm = m_state == 1 && valid && expected != actual;
        if (LOG_EN && log_pop && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_syn.pop_front());
        end
        if (mm) begin
            if (!m_seen) begin
                m_seen = 1; m_faddr = addr; m_fexp = expected; m_fact = actual;
            end
            m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
            if (LOG_EN) begin
                if (q_addr.size() < LD) begin
                    q_addr.push_back(addr);
                    q_syn.push_back(expected ^ actual);
                end else m_ovf = 1;
            end
        end
        if (m_state == 1 && pass_done) m_state = 2;
    endfunction

    task automatic check_model();
        check("m_err_count", err_count, m_cnt);
        check("m_busy", busy, m_state == 1);
        check("m_good", good, m_state == 2 && m_cnt == 0);
        check("m_bad", bad, m_state == 2 && m_cnt != 0);
        check("m_first_addr", first_addr, m_faddr);
        check("m_first_exp", first_exp, m_fexp);
        check("m_first_act", first_act, m_fact);
        check("m_log_valid", log_valid, q_addr.size() > 0);
        check("m_log_addr", log_addr, q_addr.size() > 0 ? q_addr[0] : '0);
        check("m_log_syn", log_syn, q_syn.size() > 0 ? q_syn[0] : '0);
        check("m_log_ovf", log_ovf, m_ovf);
    endtask

    task automatic step(input bit s, input bit v, input bit pd, input bit pop,
                        input logic [AW-1:0] a, input logic [DW-1:0] e, input logic [DW-1:0] act, input bit chk);
        start = s; valid = v; pass_done = pd; log_pop = pop; addr = a; expected = e; actual = act;
        model_clock();
        @(posedge clk); #1;
        start = 0; valid = 0; pass_done = 0; log_pop = 0;
        if (chk) check_model();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_good"}, good, 0);
        check({tag, "_bad"}, bad, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_first_addr"}, first_addr, 0);
        check({tag, "_first_act"}, first_act, 0);
        check({tag, "_log_valid"}, log_valid, 0);
        check({tag, "_log_ovf"}, log_ovf, 0);
        check({tag, "_log_syn"}, log_syn, 0);
    endtask

    typedef struct {
        bit s, v, pd, pop;
        logic [AW-1:0] a;
        logic [DW-1:0] e, act;
        int cnt;
        bit good, bad, busy;
    } vec_t;
    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit mm;
        logic [DW-1:0] e;
        tbl[0] = '{1, 0, 0, 0, 18'h00000, 16'h0000, 16'h0000, 0, 0, 0, 1};
        tbl[1] = '{0, 1, 0, 0, 18'h0000F, 16'h5555, 16'h5555, 0, 0, 0, 1};
        tbl[2] = '{0, 1, 0, 0, 18'h00010, 16'hA5A5, 16'hA5A4, 1, 0, 0, 1};
        tbl[3] = '{0, 1, 0, 0, 18'h00011, 16'h0000, 16'h0000, 1, 0, 0, 1};
        tbl[4] = '{0, 1, 0, 0, 18'h00020, 16'h1234, 16'h1200, 2, 0, 0, 1};
        tbl[5] = '{0, 1, 1, 0, 18'h00021, 16'hFFFF, 16'hFFFF, 2, 0, 1, 0};
        tbl[6] = '{0, 1, 0, 0, 18'h00030, 16'h0001, 16'h0002, 2, 0, 1, 0};
        m_state = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        clr_n = 1;

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].pd, tbl[i].pop, tbl[i].a, tbl[i].e, tbl[i].act, 1);
            check($sformatf("tbl%0d_cnt", i), err_count, tbl[i].cnt);
            check($sformatf("tbl%0d_good", i), good, tbl[i].good);
            check($sformatf("tbl%0d_bad", i), bad, tbl[i].bad);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
        end
        check("two_first_addr", first_addr, 18'h00010);
        check("two_first_exp", first_exp, 16'hA5A5);
        check("two_first_act", first_act, 16'hA5A4);
        check("two_log_valid0", log_valid, LOG_EN);
        check("two_log_addr0", log_addr, LOG_EN ? 18'h00010 : 18'h0);
        check("two_log_syn0", log_syn, LOG_EN ? 16'h0001 : 16'h0);
        step(0, 0, 0, 1, '0, '0, '0, 1);
        check("two_log_addr1", log_addr, LOG_EN ? 18'h00020 : 18'h0);
        check("two_log_syn1", log_syn, LOG_EN ? 16'h0034 : 16'h0);
        step(0, 0, 0, 1, '0, '0, '0, 1);
        check("two_log_empty", log_valid, 0);

        step(1, 0, 0, 0, '0, '0, '0, 1);
        check("restart_cnt", err_count, 0);
        check("restart_first", first_addr, 0);
        check("restart_bad", bad, 0);
        check("restart_busy", busy, 1);
        for (int i = 0; i < 64; i++) step(0, 1, i == 63, 0, AW'(i), DW'(i * 3), DW'(i * 3), 1);
        check("clean_good", good, 1);
        check("clean_bad", bad, 0);
        check("clean_cnt", err_count, 0);
        check("clean_log_valid", log_valid, 0);

        step(1, 0, 0, 0, '0, '0, '0, 1);
        step(0, 1, 1, 0, 18'h3FFFF, 16'h8000, 16'h0000, 1);
        check("same_cycle_cnt", err_count, 1);
        check("same_cycle_bad", bad, 1);
        check("same_cycle_good", good, 0);

        step(1, 0, 0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, AW'(32'h100 + i), 16'h00FF, 16'h0F0F, 1);
        check("ovf_cnt", err_count, 10);
        check("ovf_flag", log_ovf, LOG_EN);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_entry%0d_valid", i), log_valid, LOG_EN);
            check($sformatf("ovf_entry%0d_addr", i), log_addr, LOG_EN ? 32'h100 + i : 0);
            step(0, 0, 0, 1, '0, '0, '0, 1);
        end
        check("ovf_drained", log_valid, 0);

        step(1, 0, 0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, AW'(32'h200 + i), 16'h0000, DW'(i + 1), 1);
        step(0, 1, 0, 1, 18'h00208, 16'h0000, 16'h0009, 1);
        check("full_pushpop_ovf", log_ovf, 0);
        check("full_pushpop_head", log_addr, LOG_EN ? 18'h00201 : 18'h0);
        n = 0;
        while (log_valid && n < 20) begin
            n++;
            step(0, 0, 0, 1, '0, '0, '0, 1);
        end
        check("full_pushpop_occupancy", n, LOG_EN ? 8 : 0);

        step(1, 0, 0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, AW'(i), 16'h1111, 16'h2222, 1);
        clr_n = 0;
        #1;
        check_zero("mid_reset");
        m_state = 0;
        model_clear();
        @(posedge clk); #1;
        clr_n = 1;
        step(0, 1, 0, 0, 18'h5, 16'h1, 16'h2, 1);
        check("no_resume_cnt", err_count, 0);

        step(1, 0, 0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 65540; i++) step(0, 1, 0, 0, AW'(i), 16'hAAAA, 16'h5555, 0);
        check("sat_cnt", err_count, 16'hFFFF);
        step(0, 1, 1, 0, 18'h1, 16'hAAAA, 16'h5555, 1);
        check("sat_hold", err_count, 16'hFFFF);

        for (int p = 0; p < 4; p++) begin
            step(1, 0, 0, 0, '0, '0, '0, 1);
            for (int i = 0; i < 150; i++) begin
                mm = $urandom_range(0, 3) == 0;
                e = DW'($urandom);
                step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, i == 149, $urandom_range(0, 2) == 0,
                     AW'($urandom), e, mm ? e ^ DW'($urandom_range(1, 65535)) : e, 1);
            end
            for (int i = 0; i < 10; i++) begin
                e = DW'($urandom);
                step(0, 1, 0, $urandom_range(0, 1) == 1, AW'($urandom), e, ~e, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pram_sram_checker.md
PRAM_SRAM_CHECKER -- requirements
Module: pram_sram_checker

Interface
REQ-001 Parameters, one per line: ADDR_W 18 SRAM word-address width; DATA_W 16 data width; LOG_DEPTH 8 failure-log entries, power of two.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 clr_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 start  in  1  one-cycle pulse from the controller that begins a test pass.
REQ-005 valid  in  1  read-compare strobe; expected/actual/addr are sampled when valid is high.
REQ-006 pass_done  in  1  one-cycle pulse marking the last address of a pass.
REQ-007 addr  in  ADDR_W  SRAM address of the current read.
REQ-008 expected  in  DATA_W  pattern ROM word; actual  in  DATA_W  word read back from SRAM.
REQ-009 good, bad  out  1 each  pass verdict; busy  out  1  high in RUN.
REQ-010 err_count  out  16  number of mismatches in the current pass, saturating.
REQ-011 first_addr  out  ADDR_W, first_exp  out  DATA_W, first_act  out  DATA_W  capture of the first mismatch.
REQ-012 log_valid  out  1, log_pop  in  1, log_addr  out  ADDR_W, log_syn  out  DATA_W (expected XOR actual), log_ovf  out  1  failure-log read port.

Function
REQ-013 State machine states: IDLE, RUN, DONE; start in any state goes to RUN and clears err_count, first_*, log contents, log_ovf, good, bad.
REQ-014 RUN: each valid cycle compares expected and actual, registered; mismatch effects become visible exactly 1 cycle after the valid cycle.
REQ-015 valid is ignored in IDLE and DONE.
REQ-016 On a mismatch, err_count increments by 1 and saturates at 16'hFFFF.
REQ-017 On the first mismatch of a pass, addr, expected and actual are loaded into first_addr/first_exp/first_act; later mismatches leave them unchanged.
REQ-018 RUN -> DONE on pass_done; a valid asserted in the same cycle as pass_done is still compared and counted.
REQ-019 In DONE, good=1 and bad=0 if err_count==0, else good=0 and bad=1; both are 0 in IDLE and RUN.
REQ-020 Each mismatch pushes {addr, syndrome} into the log FIFO.
REQ-021 A push to a full log is dropped and sets sticky log_ovf; it does not overwrite an entry.
REQ-022 log_valid is high whenever the log is non-empty; log_addr/log_syn present the oldest entry (first-word fall-through).
REQ-023 log_pop with log_valid low is ignored.
REQ-024 Simultaneous push and pop while full: both succeed; occupancy stays unchanged and log_ovf is not set.
REQ-025 The log is readable in any state and is cleared only by start or reset.

Reset
REQ-026 While clr_n is low: state=IDLE; good, bad, busy, log_valid, log_ovf = 0; err_count, first_*, log pointers = 0; log_addr/log_syn = 0.
REQ-027 Reset asserted mid-pass abandons the pass immediately; there is no resume.

Configuration
REQ-028 Macro PRAM_SRAM_CHECKER_LOG_EN: when defined, the failure log of REQ-012 and REQ-020..025 is built with LOG_DEPTH entries.
REQ-029 Without PRAM_SRAM_CHECKER_LOG_EN: no log storage is built; log_valid, log_addr, log_syn and log_ovf are tied 0 and log_pop is ignored; all other behaviour is unchanged.

Structure
REQ-030 Shared package pram_sram_pkg holds: ADDR_W/DATA_W defaults, the checker state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and the ERR_CNT_MAX constant 16'hFFFF.
REQ-031 The log is a single sub-module, pram_sram_log_fifo (synchronous, first-word fall-through, depth LOG_DEPTH), instantiated only under PRAM_SRAM_CHECKER_LOG_EN.

Verification
REQ-032 Clean pass: start, 64 valid reads with expected==actual, then pass_done -> DONE, good=1, bad=0, err_count=0, log_valid=0.
REQ-033 Two errors: mismatches at addr 18'h00010 (exp 16'hA5A5, act 16'hA5A4) and 18'h00020 -> err_count=2, first_addr=18'h00010, first_act=16'hA5A4; log pops give syndromes 16'h0001 then the second; bad=1 after pass_done.
REQ-034 Log overflow (LOG_EN, depth 8): 10 mismatches with no pops -> err_count=10, log_ovf=1, 8 entries readable holding addresses of errors 1..8.
REQ-035 Boundaries: valid+pass_done in the same cycle with a mismatch -> counted, bad=1; push+pop on a full log -> occupancy stays 8, log_ovf=0; err_count preloaded near max -> holds 16'hFFFF.
REQ-036 Reset and restart: clr_n low mid-RUN -> all outputs 0, state IDLE; a start in DONE clears err_count, first_*, the log and the verdict.
REQ-037 Build without LOG_EN: run REQ-033 stimulus -> same verdict, count and first_* values; log_* outputs stay 0.
